// File: rtl/disp_pkg.sv
// Shared display definitions: segment vector type, blank/DP constants,
// hex decode table and the scanner state encoding.
package disp_pkg;

    // {dp,g,f,e,d,c,b,a}, active low
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;
    // Downstream DP stage ANDs this in to light the decimal point
    localparam seg_t DP_MASK   = 8'h7F;

    localparam seg_t HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    function automatic seg_t hex_decode(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder (dp off).
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = hex_decode(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit common-anode scanner with per-slot blanking.
// Every digit is decoded in parallel; the scanner registers the one whose
// slot is starting, so data/mask are only sampled at SHOW entry.
module seven_seg_scanner
    import disp_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int DIGITS       = 8,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     digit_mask,
    output logic [2:0]            select,
    output logic [7:0]            anode_n,
    output seg_t                  seg_n,
    output logic                  frame_tick
);

    localparam int PERIOD      = CLK_HZ / REFRESH_HZ;
    localparam int SHOW_CYCLES = PERIOD - BLANK_CYCLES;
    localparam int CNT_W       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       LAST_SEL   = 3'(DIGITS - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PERIOD) begin : g_bad_blank
            $error("BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < PERIOD");
        end
        if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
            $error("DIGITS must be in 2..8");
        end
    endgenerate

    scan_state_t          state;
    logic [CNT_W-1:0]     cnt;
    seg_t [DIGITS-1:0]    dec;
    logic [2:0]           nxt_sel;
    seg_t                 nxt_seg;
    logic [7:0]           nxt_anode;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dec
            hex_to_seg7 u_dec (
                .nibble (digit_data[4*gi +: 4]),
                .seg    (dec[gi])
            );
        end
    endgenerate

    // Digit that the next SHOW entry will drive, plus its anode/segment image
    always_comb begin
        nxt_sel   = 3'd0;
        nxt_seg   = SEG_BLANK;
        nxt_anode = 8'hFF;
        if (state == BLANK)
            nxt_sel = (select == LAST_SEL) ? 3'd0 : select + 3'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (nxt_sel == 3'(i) && digit_mask[i]) begin
                nxt_seg      = dec[i] | ~DP_MASK;
                nxt_anode[i] = 1'b0;
            end
        end
    end

    // Scan FSM: SHOW for SHOW_CYCLES, BLANK for BLANK_CYCLES, outputs registered
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state      <= IDLE;
            cnt        <= '0;
            select     <= 3'd0;
            anode_n    <= 8'hFF;
            seg_n      <= SEG_BLANK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= SHOW;
                    cnt     <= '0;
                    select  <= nxt_sel;
                    anode_n <= nxt_anode;
                    seg_n   <= nxt_seg;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state   <= BLANK;
                        cnt     <= '0;
                        anode_n <= 8'hFF;
                        seg_n   <= SEG_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state      <= SHOW;
                        cnt        <= '0;
                        select     <= nxt_sel;
                        anode_n    <= nxt_anode;
                        seg_n      <= nxt_seg;
                        frame_tick <= (nxt_sel == 3'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed scenarios plus random traffic,
// every cycle compared against a slot-arithmetic reference model.
module tb_seven_seg_scanner;

    localparam int CLK_HZ     = 1000;
    localparam int REFRESH_HZ = 100;
    localparam int DIGITS     = 8;
    localparam int BLANK      = 2;
    localparam int PERIOD     = CLK_HZ / REFRESH_HZ;
    localparam int SHOW       = PERIOD - BLANK;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] digit_data;
    logic [7:0]  digit_mask;
    logic [2:0]  select;
    logic [7:0]  anode_n;
    logic [7:0]  seg_n;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: time since scan start, plus data latched at slot start
    bit         m_active = 0;
    int         t = 0;
    logic [3:0] lat_nib;
    bit         lat_m;

    seven_seg_scanner #(
        .CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .DIGITS(DIGITS), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_data(digit_data),
        .digit_mask(digit_mask), .select(select), .anode_n(anode_n),
        .seg_n(seg_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic int m_sel();
        return (t / PERIOD) % DIGITS;
    endfunction

    function automatic int m_phase();
        return t % PERIOD;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic latch();
        lat_nib = digit_data[4*m_sel() +: 4];
        lat_m   = digit_mask[m_sel()];
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic step();
        logic [7:0] e_an, e_seg;
        logic [2:0] e_sel;
        logic       e_ft;
        @(posedge clk);
        if (reset || !enable) begin
            m_active = 0;
            t = 0;
        end else if (!m_active) begin
            m_active = 1;
            t = 0;
            latch();
        end else begin
            t++;
            if (m_phase() == 0) latch();
        end
        #1;
        e_sel = 3'd0; e_an = 8'hFF; e_seg = 8'hFF; e_ft = 1'b0;
        if (m_active) begin
            e_sel = 3'(m_sel());
            if (m_phase() < SHOW && lat_m) begin
                e_an  = ~(8'h01 << m_sel());
                e_seg = tbl[lat_nib];
            end
            e_ft = (t > 0 && m_phase() == 0 && m_sel() == 0);
        end
        chk("select", {5'd0, select}, {5'd0, e_sel});
        chk("anode_n", anode_n, e_an);
        chk("seg_n", seg_n, e_seg);
        chk("frame_tick", {7'd0, frame_tick}, {7'd0, e_ft});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model reaches slot s with phase in [lo,hi]; bounded
    task automatic wait_slot(input int s, input int lo, input int hi);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            found = m_active && m_sel() == s && m_phase() >= lo && m_phase() <= hi;
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL wait_slot%0d: got timeout expected slot reached", s);
        end
    endtask

    initial begin
        int ft_count;
        reset = 1'b1; enable = 1'b0;
        digit_data = 32'h7654_3210; digit_mask = 8'hFF;
        steps(2);
        chk("reset_anode", anode_n, 8'hFF);

        // First slot and transition to digit 1
        reset = 1'b0; enable = 1'b1;
        step();
        chk("first_anode", anode_n, 8'hFE);
        chk("first_seg", seg_n, 8'hC0);
        steps(9);
        chk("blank_anode", anode_n, 8'hFF);
        step();
        chk("sel1_anode", anode_n, 8'hFD);
        chk("sel1_seg", seg_n, 8'hF9);

        // Three frames free run; count frame ticks
        ft_count = 0;
        for (int i = 0; i < 3 * DIGITS * PERIOD; i++) begin
            step();
            if (frame_tick) ft_count++;
        end
        chk("ft_count", 8'(ft_count), 8'd3);

        // Masked digit 2
        digit_mask = 8'b1111_1011;
        wait_slot(2, 0, 0);
        chk("mask_anode", anode_n, 8'hFF);
        steps(DIGITS * PERIOD);
        digit_mask = 8'hFF;

        // Mid-SHOW data change on digit 3
        wait_slot(3, 2, 4);
        digit_data[15:12] = 4'hF;
        wait_slot(3, 7, 7);
        chk("tear_seg", seg_n, 8'hB0);
        wait_slot(3, 0, 0);
        chk("new_seg", seg_n, 8'h8E);

        // Enable drop in SHOW of select 5, then re-enable
        wait_slot(5, 3, 3);
        enable = 1'b0;
        step();
        chk("off_anode", anode_n, 8'hFF);
        chk("off_sel", {5'd0, select}, 8'd0);
        enable = 1'b1;
        step();
        chk("reen_seg", seg_n, 8'hC0);
        steps(30);

        // Reset pulse during BLANK
        wait_slot(4, SHOW, SHOW);
        reset = 1'b1;
        step();
        chk("rst_seg", seg_n, 8'hFF);
        reset = 1'b0;
        step();
        chk("rst_restart_anode", anode_n, 8'hFE);

        // Decode sweep on digit 0
        for (int n = 0; n < 16; n++) begin
            digit_data[3:0] = 4'(n);
            enable = 1'b0;
            step();
            enable = 1'b1;
            step();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) digit_data = $urandom;
            if ($urandom_range(0, 39) == 0) digit_mask = 8'($urandom);
            if ($urandom_range(0, 249) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.
- Owns the digit-select counter and steps it through all digits at a fixed refresh rate, inserting an anti-ghosting blank interval between digits.
- Decodes each digit's hex nibble into active-low segment data.
- Its `select` and `seg_n` outputs feed the clock's digital-point stage, which clears bit 7 on selects 3 and 5. `anode_n` goes straight to the display.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency.
- `REFRESH_HZ`, 1000: digit slot rate; slot length PERIOD = CLK_HZ/REFRESH_HZ cycles.
- `DIGITS`, 8: digit count, 2..8; `select` stays 3 bits.
- `BLANK_CYCLES`, 1000: blank cycles at the end of each slot. Elaboration error unless 1 ≤ BLANK_CYCLES < PERIOD.

Ports (one clock `clk`; reset is synchronous and active-high, port `reset`):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  1 = scan, 0 = display dark
- `digit_data`  in  4*DIGITS  hex nibble per digit; digit i at [4i+3:4i]
- `digit_mask`  in  DIGITS  1 = digit lit, 0 = digit blank
- `select`  out  3  index of the digit currently driven
- `anode_n`  out  8  active-low anode enables; bits ≥ DIGITS always 1
- `seg_n`  out  8  {dp,g,f,e,d,c,b,a}, active low; dp is always driven 1 (off)
- `frame_tick`  out  1  one-cycle pulse when `select` wraps to 0

## Operation
- FSM states: IDLE, SHOW, BLANK. A cycle counter `cnt` counts within each state.
- Reset values: state IDLE, `select` 0, `anode_n` 8'hFF, `seg_n` 8'hFF, `frame_tick` 0, `cnt` 0.
- IDLE → SHOW on the first edge with `enable`=1. That edge loads:
  - `select` 0;
  - `anode_n[0]` low, or `anode_n` 8'hFF if `digit_mask[0]`=0;
  - `seg_n` = decode(digit 0), or 8'hFF if masked.
- SHOW lasts SHOW_CYCLES = PERIOD−BLANK_CYCLES cycles, then → BLANK.
- Entering BLANK: `anode_n` 8'hFF, `seg_n` 8'hFF, `select` held.
- BLANK lasts BLANK_CYCLES cycles, then → SHOW with `select` = (select==DIGITS−1) ? 0 : select+1. The new digit's data and mask load on that same edge.
- `frame_tick`=1 for exactly the cycle after an edge on which `select` went from DIGITS−1 to 0. The initial IDLE→SHOW entry does not pulse.
- Data and mask are sampled only on SHOW entry. Changes during SHOW or BLANK take effect in the next slot, so there is no mid-digit tearing.
- `enable`=0 in any state: next edge → IDLE with all reset values. Re-enable always restarts at digit 0.
- `reset` mid-scan: reset values on the next edge, regardless of `enable`.
- Decode, nibble 0..F → seg_n: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

## Timing
- All outputs are registered. `select`, `anode_n` and `seg_n` change on the same edge, so downstream combinational DP logic stays aligned with the anode.
- Per slot: exactly SHOW_CYCLES cycles with one anode low, then BLANK_CYCLES cycles with all anodes high.
- Frame length is DIGITS*PERIOD cycles. `frame_tick` period equals the frame length in steady state.
- Latency:
  - `enable` rise → first anode low: 1 edge.
  - `enable` fall → all anodes high: 1 edge.
- `cnt` width is $clog2(PERIOD). `cnt` compares against SHOW_CYCLES−1 and BLANK_CYCLES−1; it never wraps past a terminal count.

## Structure
- Shared package `disp_pkg` holds:
  - `seg_t` (8-bit active-low segment vector);
  - the constants SEG_BLANK = 8'hFF and DP_MASK = 8'h7F;
  - the 16-entry hex decode constant array;
  - the `scan_state_t` enum (IDLE/SHOW/BLANK).
- One sub-module, `hex_to_seg7`: combinational nibble → `seg_t` decoder built on the package table. It is reusable by other display paths. The scanner registers its output.

## Test plan
All scenarios use CLK_HZ=1000, REFRESH_HZ=100 (PERIOD=10), BLANK_CYCLES=2, DIGITS=8.
- Reset, then `enable`=1 with digit_data=32'h7654_3210 and mask 8'hFF → after 1 edge: `select`=0, `anode_n`=8'hFE, `seg_n`=8'hC0 held 8 cycles. Then 2 cycles at anode_n=8'hFF/seg_n=8'hFF, then `select`=1, `anode_n`=8'hFD, `seg_n`=8'hF9.
- Free run for 3 frames → `select` sequence 0..7 repeats. `frame_tick` is high for 1 cycle every 80 cycles, aligned with `select` becoming 0. No cycle has two anodes low.
- Mask 8'b1111_1011 → slot for select=2 keeps `anode_n`=8'hFF and `seg_n`=8'hFF for all 10 cycles. Timing of the other slots is unchanged.
- Change digit 3 from 3 to F mid-SHOW of select=3 → `seg_n` stays 8'hB0 for that slot and shows 8'h8E on the next frame's select=3.
- Deassert `enable` during SHOW of select=5 → next edge: `anode_n`=8'hFF, `select`=0. Re-enable → restarts at select=0 with `seg_n`=8'hC0, and no `frame_tick` is generated.
- Assert `reset` for 1 cycle during BLANK with `enable` held 1 → reset values for 1 cycle, then scan restarts at select=0. Also sweep nibbles 0..F on digit 0 and check all 16 decode values.
